// File: rtl/issue_scoreboard_pkg.sv
// Shared types and widths for the issue-slot register scoreboard.
package issue_scoreboard_pkg;

    localparam int unsigned ISSUE_RATIO = 4;
    localparam int unsigned WIS_W       = 2;
    localparam int unsigned NUM_REGS    = 64;
    localparam int unsigned NR_BITS     = 6;
    localparam int unsigned PAYLOAD_W   = 128;

    localparam int unsigned SB_REQ_W    = PAYLOAD_W + 1 + WIS_W + 4 * NR_BITS;
    localparam int unsigned OUT_W       = PAYLOAD_W + 2 + WIS_W + 4 * NR_BITS;

    // Field order matches the operand-fetch bus: {payload, wb, wis, rd, rs1, rs2, rs3}
    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic                 wb;
        logic [WIS_W-1:0]     wis;
        logic [NR_BITS-1:0]   rd;
        logic [NR_BITS-1:0]   rs1;
        logic [NR_BITS-1:0]   rs2;
        logic [NR_BITS-1:0]   rs3;
    } sb_req_t;

endpackage

// File: rtl/issue_scoreboard_pipe_reg.sv
// One-entry valid/ready register; refills in the same cycle it drains.
module sb_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid & in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Per-issue-slot register scoreboard: holds RAW/WAW hazards, forwards clean instructions.
// Optional SCOREBOARD_PERF_EN adds a saturating stall counter and a per-warp stall-timeout check.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ibuf_valid,
    output logic                 ibuf_ready,
    input  logic [WIS_W-1:0]     ibuf_wis,
    input  logic                 ibuf_wb,
    input  logic [NR_BITS-1:0]   ibuf_rd,
    input  logic [NR_BITS-1:0]   ibuf_rs1,
    input  logic [NR_BITS-1:0]   ibuf_rs2,
    input  logic [NR_BITS-1:0]   ibuf_rs3,
    input  logic [PAYLOAD_W-1:0] ibuf_data,
    input  logic                 wb_valid,
    input  logic [WIS_W-1:0]     wb_wis,
    input  logic [NR_BITS-1:0]   wb_rd,
    input  logic                 wb_eop,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef SCOREBOARD_PERF_EN
    output logic [31:0]          perf_stalls,
`endif
    output logic [OUT_W-1:0]     out_data
);

    logic [NUM_REGS-1:0]    inuse [ISSUE_RATIO];
    logic                   hazard;
    logic                   pipe_in_valid;
    logic                   pipe_in_ready;
    logic                   fire;
    logic                   set_en;
    logic                   clr_en;
    logic [ISSUE_RATIO-1:0] set_wis_oh;
    logic [ISSUE_RATIO-1:0] clr_wis_oh;
    logic [NUM_REGS-1:0]    set_reg_oh;
    logic [NUM_REGS-1:0]    clr_reg_oh;
    sb_req_t                req;

    always_comb begin
        req         = '0;
        req.payload = ibuf_data;
        req.wb      = ibuf_wb;
        req.wis     = ibuf_wis;
        req.rd      = ibuf_rd;
        req.rs1     = ibuf_rs1;
        req.rs2     = ibuf_rs2;
        req.rs3     = ibuf_rs3;
    end

    // Bit 0 of every warp is never set, so r0 can never raise a hazard.
    assign hazard = inuse[ibuf_wis][ibuf_rs1]
                  | inuse[ibuf_wis][ibuf_rs2]
                  | inuse[ibuf_wis][ibuf_rs3]
                  | (ibuf_wb & inuse[ibuf_wis][ibuf_rd]);

    assign pipe_in_valid = ~reset & ibuf_valid & ~hazard;
    assign ibuf_ready    = pipe_in_valid & pipe_in_ready;
    assign fire          = ibuf_ready;

    assign set_en     = fire & ibuf_wb & (ibuf_rd != '0);
    assign clr_en     = wb_valid & wb_eop & (wb_rd != '0);
    assign set_wis_oh = set_en ? (ISSUE_RATIO'(1) << ibuf_wis) : '0;
    assign clr_wis_oh = clr_en ? (ISSUE_RATIO'(1) << wb_wis) : '0;
    assign set_reg_oh = NUM_REGS'(1) << ibuf_rd;
    assign clr_reg_oh = NUM_REGS'(1) << wb_rd;

    // Clear is applied first so a same-cycle claim by a new instruction wins.
    always_ff @(posedge clk) begin
        for (int unsigned w = 0; w < ISSUE_RATIO; w++) begin
            if (reset) begin
                inuse[w] <= '0;
            end else begin
                inuse[w] <= (inuse[w] & ~({NUM_REGS{clr_wis_oh[w]}} & clr_reg_oh))
                          | ({NUM_REGS{set_wis_oh[w]}} & set_reg_oh);
            end
        end
    end

    sb_pipe_reg #(
        .W (OUT_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (pipe_in_valid),
        .in_ready  (pipe_in_ready),
        .in_data   ({1'b0, req}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

`ifndef SYNTHESIS
    // A release is legitimate if the register is pending or is being claimed in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset && clr_en) begin
            assert (inuse[wb_wis][wb_rd] || (set_en && ibuf_wis == wb_wis && ibuf_rd == wb_rd))
                else $error("issue_scoreboard: eop writeback to idle register wis=%0d rd=%0d",
                            wb_wis, wb_rd);
        end
    end
`endif

`ifdef SCOREBOARD_PERF_EN
    logic stall;

    assign stall = ibuf_valid & hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stalls <= '0;
        end else if (stall && perf_stalls != '1) begin
            perf_stalls <= perf_stalls + 32'd1;
        end
    end

`ifndef SYNTHESIS
    localparam int unsigned STALL_TIMEOUT = 10000;
    localparam int unsigned AGE_W         = 14;

    logic [AGE_W-1:0] stall_age [ISSUE_RATIO];

    always_ff @(posedge clk) begin
        for (int unsigned w = 0; w < ISSUE_RATIO; w++) begin
            if (reset) begin
                stall_age[w] <= '0;
            end else if (stall && ibuf_wis == WIS_W'(w)) begin
                assert (stall_age[w] != AGE_W'(STALL_TIMEOUT - 1))
                    else $error("issue_scoreboard: warp %0d stalled for %0d cycles", w, STALL_TIMEOUT);
                if (stall_age[w] != AGE_W'(STALL_TIMEOUT)) begin
                    stall_age[w] <= stall_age[w] + AGE_W'(1);
                end
            end else begin
                stall_age[w] <= '0;
            end
        end
    end
`endif
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized bench for issue_scoreboard against a per-warp pending-register model.
module tb_issue_scoreboard;

    localparam int unsigned OW = 128 + 2 + 2 + 4 * 6;
    localparam int unsigned CW = 256;
    localparam int unsigned N_RANDOM = 2000;

    logic          clk = 1'b0;
    logic          reset;
    logic          ibuf_valid;
    logic          ibuf_ready;
    logic [1:0]    ibuf_wis;
    logic          ibuf_wb;
    logic [5:0]    ibuf_rd;
    logic [5:0]    ibuf_rs1;
    logic [5:0]    ibuf_rs2;
    logic [5:0]    ibuf_rs3;
    logic [127:0]  ibuf_data;
    logic          wb_valid;
    logic [1:0]    wb_wis;
    logic [5:0]    wb_rd;
    logic          wb_eop;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;

    int checks   = 0;
    int failures = 0;

    // Reference state: set of pending destination registers per warp, plus the output slot.
    bit [63:0]     m_pending [4];
    bit            m_ov;
    logic [OW-1:0] m_od;
    bit            last_fire;

    issue_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .ibuf_valid (ibuf_valid),
        .ibuf_ready (ibuf_ready),
        .ibuf_wis   (ibuf_wis),
        .ibuf_wb    (ibuf_wb),
        .ibuf_rd    (ibuf_rd),
        .ibuf_rs1   (ibuf_rs1),
        .ibuf_rs2   (ibuf_rs2),
        .ibuf_rs3   (ibuf_rs3),
        .ibuf_data  (ibuf_data),
        .wb_valid   (wb_valid),
        .wb_wis     (wb_wis),
        .wb_rd      (wb_rd),
        .wb_eop     (wb_eop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit reads_pending(input bit [63:0] pend, input logic [5:0] r);
        return (r != 6'd0) && pend[r];
    endfunction

    function automatic bit m_hazard();
        bit [63:0] p;
        p = m_pending[ibuf_wis];
        return reads_pending(p, ibuf_rs1) || reads_pending(p, ibuf_rs2) ||
               reads_pending(p, ibuf_rs3) || (ibuf_wb && reads_pending(p, ibuf_rd));
    endfunction

    // One clock: check accept decision, advance the model, then check the output slot.
    task automatic tick();
        bit exp_ready;
        #1;
        exp_ready = !reset && ibuf_valid && !m_hazard() && (!m_ov || out_ready);
        check_eq("ibuf_ready", CW'(ibuf_ready), CW'(exp_ready));
        @(posedge clk);
        if (reset) begin
            for (int w = 0; w < 4; w++) m_pending[w] = '0;
            m_ov = 1'b0;
            m_od = '0;
        end else begin
            if (wb_valid && wb_eop && wb_rd != 6'd0) m_pending[wb_wis][wb_rd] = 1'b0;
            if (exp_ready && ibuf_wb && ibuf_rd != 6'd0) m_pending[ibuf_wis][ibuf_rd] = 1'b1;
            if (exp_ready) begin
                m_ov = 1'b1;
                m_od = {1'b0, ibuf_data, ibuf_wb, ibuf_wis, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3};
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
        last_fire = exp_ready;
        #1;
        check_eq("out_valid", CW'(out_valid), CW'(m_ov));
        check_eq("out_data", CW'(out_data), CW'(m_od));
    endtask

    task automatic set_ins(input logic v, input logic [1:0] wis, input logic wb, input logic [5:0] rd,
                           input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rs3);
        ibuf_valid = v;
        ibuf_wis   = wis;
        ibuf_wb    = wb;
        ibuf_rd    = rd;
        ibuf_rs1   = rs1;
        ibuf_rs2   = rs2;
        ibuf_rs3   = rs3;
        ibuf_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_wb(input logic v, input logic [1:0] wis, input logic [5:0] rd, input logic eop);
        wb_valid = v;
        wb_wis   = wis;
        wb_rd    = rd;
        wb_eop   = eop;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] w;
        logic [5:0] r;
        m_ov = 1'b0;
        m_od = '0;
        last_fire = 1'b0;
        for (int i = 0; i < 4; i++) m_pending[i] = '0;
        reset     = 1'b1;
        out_ready = 1'b1;
        set_wb(1'b0, 2'd0, 6'd0, 1'b0);
        set_ins(1'b1, 2'd0, 1'b1, 6'd5, 6'd0, 6'd0, 6'd0);

        // Reset holds off issue
        tick();
        tick();
        reset = 1'b0;

        // Claim r5 on warp 0, then a reader of r5 stalls until the eop beat lands
        tick();
        set_ins(1'b1, 2'd0, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0);
        tick();
        set_wb(1'b1, 2'd0, 6'd5, 1'b0);
        tick();
        set_wb(1'b1, 2'd0, 6'd5, 1'b1);
        tick();
        set_wb(1'b0, 2'd0, 6'd0, 1'b0);
        tick();

        // Per-warp isolation: r5 pending on warp 0 does not block warp 1
        set_ins(1'b1, 2'd0, 1'b1, 6'd5, 6'd0, 6'd0, 6'd0);
        tick();
        set_ins(1'b1, 2'd1, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0);
        tick();

        // Backpressure: output held three cycles, then refilled in the drain cycle
        out_ready = 1'b0;
        set_ins(1'b1, 2'd3, 1'b0, 6'd1, 6'd2, 6'd3, 6'd4);
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        tick();

        // Same-cycle claim and release of r7 on warp 2: claim wins, reader then stalls
        set_ins(1'b1, 2'd2, 1'b1, 6'd7, 6'd0, 6'd0, 6'd0);
        set_wb(1'b1, 2'd2, 6'd7, 1'b1);
        tick();
        set_wb(1'b0, 2'd0, 6'd0, 1'b0);
        set_ins(1'b1, 2'd2, 1'b0, 6'd0, 6'd0, 6'd7, 6'd0);
        tick();
        set_wb(1'b1, 2'd2, 6'd7, 1'b1);
        tick();
        set_wb(1'b0, 2'd0, 6'd0, 1'b0);
        tick();

        // r0 is never tracked
        set_ins(1'b1, 2'd1, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0);
        tick();
        set_ins(1'b1, 2'd1, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        tick();

        // Randomized traffic on a small register window so hazards are frequent
        for (int n = 0; n < N_RANDOM; n++) begin
            if (!(ibuf_valid && !last_fire)) begin
                set_ins(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                        6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                        6'($urandom_range(0, 7)));
            end
            out_ready = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                w = 2'($urandom_range(0, 3));
                r = 6'($urandom_range(0, 7));
                set_wb(1'b1, w, r, m_pending[w][r] ? 1'($urandom_range(0, 1)) : 1'b0);
            end else begin
                set_wb(1'b0, 2'd0, 6'd0, 1'b0);
            end
            tick();
        end

        // Drain every pending register
        ibuf_valid = 1'b0;
        out_ready  = 1'b1;
        for (int wi = 0; wi < 4; wi++) begin
            for (int ri = 1; ri < 8; ri++) begin
                if (m_pending[wi][ri]) begin
                    set_wb(1'b1, 2'(wi), 6'(ri), 1'b1);
                    tick();
                end
            end
        end
        set_wb(1'b0, 2'd0, 6'd0, 1'b0);
        tick();

        // Reset mid-operation drops the held output and all pending registers
        set_ins(1'b1, 2'd3, 1'b1, 6'd3, 6'd0, 6'd0, 6'd0);
        tick();
        ibuf_valid = 1'b0;
        out_ready  = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        set_ins(1'b1, 2'd3, 1'b0, 6'd0, 6'd3, 6'd0, 6'd0);
        tick();
        ibuf_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
